// File: rtl/pipeline_flow_ctrl.sv
// pipeline_flow_ctrl: AXI-Stream wrapper around a fixed-latency cen-gated pipeline,
// using credit admission into a first-word-fall-through output FIFO.
module pipeline_flow_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int PIPE_STAGES = 8,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH:0]   pipe_in,
    output logic                  pipe_cen,
    input  logic [DATA_WIDTH:0]   pipe_out,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [CW-1:0]          credit, inflight, count;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [PIPE_STAGES-1:0] tag;
    logic [DATA_WIDTH:0]    mem [FIFO_DEPTH];
    logic                   accept, pop, wr;
    assign s_axis_tready = (credit != '0) && !srst;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign m_axis_tvalid = (count != '0) && !srst;
    assign pop           = m_axis_tvalid && m_axis_tready;
    // cen may only stop once no tagged beat remains inside the pipeline
    assign pipe_cen      = !srst && (accept || (inflight != '0));
    assign wr            = tag[PIPE_STAGES-1] && pipe_cen;
    assign pipe_in       = {s_axis_tlast, s_axis_tdata};
    assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (srst) begin
            credit   <= CW'(FIFO_DEPTH);
            inflight <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tag      <= '0;
        end else begin
            credit   <= credit - CW'(accept) + CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(wr);
            count    <= count + CW'(wr) - CW'(pop);
            wr_ptr   <= wr_ptr + AW'(wr);
            rd_ptr   <= rd_ptr + AW'(pop);
            if (pipe_cen) tag <= (tag << 1) | PIPE_STAGES'(accept);
        end
    end
    always_ff @(posedge clk) if (wr) mem[wr_ptr] <= pipe_out;
    assert property (@(posedge clk) disable iff (srst)
        32'(credit) + 32'(inflight) + 32'(count) == 32'(FIFO_DEPTH));
    assert property (@(posedge clk) disable iff (srst) !(wr && count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// tb_pipeline_flow_ctrl: directed and random checks of pipeline_flow_ctrl with
// behavioural cen-gated pipelines, for the 8/16 and 1/2 configurations.
module tb_pipeline_flow_ctrl;
    localparam int DW = 32, P = 8, D = 16;
    logic clk = 1'b0, srst = 1'b1;
    logic [DW-1:0] s_tdata = '0, m_tdata;
    logic s_tlast = 1'b0, s_tvalid = 1'b0, s_tready, m_tlast, m_tvalid, m_tready = 1'b0, pipe_cen;
    logic [DW:0] pipe_in, pipe_out;
    logic [DW-1:0] b_s_tdata = '0, b_m_tdata;
    logic b_s_tlast = 1'b0, b_s_tvalid = 1'b0, b_s_tready, b_m_tlast, b_m_tvalid, b_m_tready = 1'b0, b_cen;
    logic [DW:0] b_in, b_out;
    logic [DW:0] pq [P];
    logic [DW:0] bq;
    typedef struct {logic [DW:0] dat; int t;} beat_t;
    beat_t q[$];
    int edge_n = 0, n_cmp = 0, n_err = 0;
    logic got_rdy, exp_rdy, got_vld, exp_vld, got_cen, exp_cen, acc, pop;
    logic [DW:0] got_dat, exp_dat;

    always #5 clk = ~clk;

    pipeline_flow_ctrl #(.DATA_WIDTH(DW), .PIPE_STAGES(P), .FIFO_DEPTH(D)) dut (
        .clk(clk), .srst(srst), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .pipe_in(pipe_in),
        .pipe_cen(pipe_cen), .pipe_out(pipe_out), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready));

    pipeline_flow_ctrl #(.DATA_WIDTH(DW), .PIPE_STAGES(1), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .srst(srst), .s_axis_tdata(b_s_tdata), .s_axis_tlast(b_s_tlast),
        .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .pipe_in(b_in),
        .pipe_cen(b_cen), .pipe_out(b_out), .m_axis_tdata(b_m_tdata),
        .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready));

    always @(posedge clk) if (pipe_cen) begin
        pq[0] <= pipe_in;
        for (int i = 1; i < P; i++) pq[i] <= pq[i-1];
    end
    assign pipe_out = pq[P-1];
    always @(posedge clk) if (b_cen) bq <= b_in;
    assign b_out = bq;

    task automatic cyc();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Drives one cycle on the selected DUT and advances the reference model;
    // a beat accepted at edge k becomes visible once edge k+stages has passed.
    task automatic run_cycle(input bit sel, input logic v, input logic [DW-1:0] d,
                             input logic l, input logic r);
        int stages = sel ? 1 : P;
        int depth = sel ? 2 : D;
        beat_t b;
        if (sel) begin
            b_s_tvalid = v; b_s_tdata = d; b_s_tlast = l; b_m_tready = r;
        end else begin
            s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
        end
        #1;
        got_rdy = sel ? b_s_tready : s_tready;
        got_vld = sel ? b_m_tvalid : m_tvalid;
        got_cen = sel ? b_cen : pipe_cen;
        got_dat = sel ? {b_m_tlast, b_m_tdata} : {m_tlast, m_tdata};
        exp_rdy = q.size() < depth;
        exp_vld = q.size() != 0 && q[0].t <= edge_n;
        exp_dat = q.size() != 0 ? q[0].dat : '0;
        acc = v && got_rdy;
        pop = got_vld && r;
        if (pop && q.size() != 0) void'(q.pop_front());
        if (acc) begin
            b.dat = {l, d};
            b.t = edge_n + 1 + stages;
            q.push_back(b);
        end
        exp_cen = q.size() != 0 && q[$].t > edge_n;
        cyc();
    endtask

    task automatic test_reset();
        s_tvalid = 1'b1;
        b_s_tvalid = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready got=%b exp=0", s_tready); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        n_cmp++; if (pipe_cen !== 1'b0) begin n_err++; $display("FAIL reset_cen got=%b exp=0", pipe_cen); end
        n_cmp++; if (b_s_tready !== 1'b0) begin n_err++; $display("FAIL reset_b_tready got=%b exp=0", b_s_tready); end
        s_tvalid = 1'b0;
        b_s_tvalid = 1'b0;
        srst = 1'b0;
        #1;
        n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL post_reset_tready got=%b exp=1", s_tready); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL post_reset_tvalid got=%b exp=0", m_tvalid); end
        n_cmp++; if (dut.credit !== 5'd16) begin n_err++; $display("FAIL post_reset_credit got=%0d exp=16", dut.credit); end
        n_cmp++; if (b_s_tready !== 1'b1) begin n_err++; $display("FAIL post_reset_b_tready got=%b exp=1", b_s_tready); end
        cyc();
    endtask

    task automatic test_single();
        int c0 = edge_n, cur;
        run_cycle(0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
        n_cmp++; if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept got=%b exp=1", acc); end
        for (int i = 0; i < 12; i++) begin
            cur = edge_n;
            run_cycle(0, 1'b0, '0, 1'b0, 1'b1);
            n_cmp++; if (got_vld !== (cur == c0 + 9)) begin n_err++; $display("FAIL single_tvalid cyc=%0d got=%b exp=%b", cur - c0, got_vld, cur == c0 + 9); end
            n_cmp++; if (got_cen !== (cur < c0 + 9)) begin n_err++; $display("FAIL single_cen cyc=%0d got=%b exp=%b", cur - c0, got_cen, cur < c0 + 9); end
            if (cur == c0 + 9) begin
                n_cmp++; if (got_dat !== 33'h1_A5A5_0001) begin n_err++; $display("FAIL single_data got=%h exp=1a5a50001", got_dat); end
            end
        end
    endtask

    task automatic test_stream();
        int sent = 0, pops = 0, first_acc = -1, first_pop = -1, last_pop = -1, cur;
        for (int c = 0; c < 200 && (sent < 100 || q.size() != 0); c++) begin
            cur = edge_n;
            run_cycle(0, sent < 100, 32'(sent), (sent % 10) == 9, 1'b1);
            if (sent < 100) begin
                n_cmp++; if (got_rdy !== 1'b1) begin n_err++; $display("FAIL stream_tready beat=%0d got=%b exp=1", sent, got_rdy); end
            end
            n_cmp++; if (got_vld !== exp_vld) begin n_err++; $display("FAIL stream_tvalid got=%b exp=%b", got_vld, exp_vld); end
            n_cmp++; if (got_cen !== exp_cen) begin n_err++; $display("FAIL stream_cen got=%b exp=%b", got_cen, exp_cen); end
            if (pop) begin
                n_cmp++; if (got_dat !== exp_dat) begin n_err++; $display("FAIL stream_data got=%h exp=%h", got_dat, exp_dat); end
                pops++;
                if (first_pop < 0) first_pop = cur;
                last_pop = cur;
            end
            if (acc) begin
                if (first_acc < 0) first_acc = cur;
                sent++;
            end
        end
        n_cmp++; if (pops != 100) begin n_err++; $display("FAIL stream_count got=%0d exp=100", pops); end
        n_cmp++; if (first_pop - first_acc != 9) begin n_err++; $display("FAIL stream_latency got=%0d exp=9", first_pop - first_acc); end
        n_cmp++; if (last_pop - first_pop != 99) begin n_err++; $display("FAIL stream_gapless got=%0d exp=99", last_pop - first_pop); end
    endtask

    task automatic test_backpressure();
        int accepted = 0, pops = 0;
        bit popped = 0, checked = 0;
        for (int c = 0; c < 30; c++) begin
            run_cycle(0, 1'b1, 32'(200 + accepted), 1'b0, 1'b0);
            n_cmp++; if (got_rdy !== exp_rdy) begin n_err++; $display("FAIL bp_tready cyc=%0d got=%b exp=%b", c, got_rdy, exp_rdy); end
            n_cmp++; if (got_cen !== exp_cen) begin n_err++; $display("FAIL bp_cen cyc=%0d got=%b exp=%b", c, got_cen, exp_cen); end
            if (acc) accepted++;
        end
        n_cmp++; if (accepted != 16) begin n_err++; $display("FAIL bp_accepted got=%0d exp=16", accepted); end
        n_cmp++; if (got_rdy !== 1'b0) begin n_err++; $display("FAIL bp_full_tready got=%b exp=0", got_rdy); end
        n_cmp++; if (got_cen !== 1'b0) begin n_err++; $display("FAIL bp_full_cen got=%b exp=0", got_cen); end
        for (int c = 0; c < 40 && q.size() != 0; c++) begin
            run_cycle(0, 1'b0, '0, 1'b0, 1'b1);
            if (popped && !checked) begin
                checked = 1;
                n_cmp++; if (got_rdy !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_pop got=%b exp=1", got_rdy); end
            end
            if (pop) begin
                n_cmp++; if (got_dat !== exp_dat) begin n_err++; $display("FAIL bp_data got=%h exp=%h", got_dat, exp_dat); end
                pops++;
                popped = 1;
            end
        end
        n_cmp++; if (pops != 16) begin n_err++; $display("FAIL bp_drained got=%0d exp=16", pops); end
    endtask

    task automatic test_random();
        int sent = 0, sum;
        logic pv = 1'b0, pl = 1'b0, r;
        logic [DW-1:0] pd = '0;
        for (int c = 0; c < 80000 && (sent < 10000 || q.size() != 0); c++) begin
            if (!pv && sent < 10000 && $urandom_range(0, 1) == 1) begin
                pv = 1'b1; pd = $urandom; pl = 1'($urandom_range(0, 1));
            end
            r = sent >= 10000 ? 1'b1 : ($urandom_range(0, 9) < 3);
            run_cycle(0, pv, pd, pl, r);
            n_cmp++; if (got_rdy !== exp_rdy) begin n_err++; $display("FAIL rand_tready cyc=%0d got=%b exp=%b", c, got_rdy, exp_rdy); end
            n_cmp++; if (got_vld !== exp_vld) begin n_err++; $display("FAIL rand_tvalid cyc=%0d got=%b exp=%b", c, got_vld, exp_vld); end
            if (pop) begin
                n_cmp++; if (got_dat !== exp_dat) begin n_err++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, got_dat, exp_dat); end
            end
            sum = int'(dut.credit) + int'(dut.inflight) + int'(dut.count);
            n_cmp++; if (sum != 16) begin n_err++; $display("FAIL rand_invariant cyc=%0d got=%0d exp=16", c, sum); end
            if (acc) begin pv = 1'b0; sent++; end
        end
        n_cmp++; if (sent != 10000 || q.size() != 0) begin n_err++; $display("FAIL rand_complete sent=%0d left=%0d exp=10000/0", sent, q.size()); end
    endtask

    task automatic test_reset_mid();
        int vis = 0;
        for (int i = 0; i < 12; i++) run_cycle(0, 1'b1, 32'(300 + i), 1'b0, 1'b0);
        for (int c = 0; c < 20 && vis < 7; c++) begin
            run_cycle(0, 1'b0, '0, 1'b0, 1'b0);
            vis = 0;
            foreach (q[i]) if (q[i].t <= edge_n) vis++;
        end
        n_cmp++; if (dut.count !== 5'd7) begin n_err++; $display("FAIL mid_buffered got=%0d exp=7", dut.count); end
        n_cmp++; if (dut.inflight !== 5'd5) begin n_err++; $display("FAIL mid_inflight got=%0d exp=5", dut.inflight); end
        srst = 1'b1;
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_srst_tvalid got=%b exp=0", m_tvalid); end
        cyc();
        srst = 1'b0;
        q.delete();
        #1;
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL mid_after_tvalid got=%b exp=0", m_tvalid); end
        n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL mid_after_tready got=%b exp=1", s_tready); end
        n_cmp++; if (dut.credit !== 5'd16) begin n_err++; $display("FAIL mid_after_credit got=%0d exp=16", dut.credit); end
        for (int c = 0; c < 14; c++) begin
            run_cycle(0, 1'b0, '0, 1'b0, 1'b1);
            n_cmp++; if (got_vld !== 1'b0) begin n_err++; $display("FAIL mid_stale cyc=%0d got=%b data=%h exp=0", c, got_vld, got_dat); end
        end
        run_cycle(0, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b1);
        for (int c = 0; c < 12; c++) begin
            run_cycle(0, 1'b0, '0, 1'b0, 1'b1);
            n_cmp++; if (got_vld !== exp_vld) begin n_err++; $display("FAIL mid_resume_tvalid got=%b exp=%b", got_vld, exp_vld); end
            if (pop) begin
                n_cmp++; if (got_dat !== 33'h1_0BAD_F00D) begin n_err++; $display("FAIL mid_resume_data got=%h exp=10badf00d", got_dat); end
            end
        end
    endtask

    task automatic test_small();
        int c0 = edge_n, sent = 0, cur;
        logic pv = 1'b0;
        logic [DW-1:0] pd = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        run_cycle(1, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cur = edge_n;
            run_cycle(1, 1'b0, '0, 1'b0, 1'b1);
            n_cmp++; if (got_vld !== (cur == c0 + 2)) begin n_err++; $display("FAIL small_latency cyc=%0d got=%b exp=%b", cur - c0, got_vld, cur == c0 + 2); end
            if (cur == c0 + 2) begin
                n_cmp++; if (got_dat !== 33'h0_1234_5678) begin n_err++; $display("FAIL small_single_data got=%h exp=012345678", got_dat); end
            end
        end
        for (int c = 0; c < 200 && (sent < 60 || q.size() != 0); c++) begin
            if (!pv && sent < 60) begin pv = 1'b1; pd = 32'hC000_0000 + 32'(sent); end
            run_cycle(1, pv, pd, pd[0], sent >= 60 ? 1'b1 : 1'(c % 2));
            n_cmp++; if (got_rdy !== exp_rdy) begin n_err++; $display("FAIL small_tready cyc=%0d got=%b exp=%b", c, got_rdy, exp_rdy); end
            n_cmp++; if (got_vld !== exp_vld) begin n_err++; $display("FAIL small_tvalid cyc=%0d got=%b exp=%b", c, got_vld, exp_vld); end
            n_cmp++; if (dut_b.credit > 2'd2) begin n_err++; $display("FAIL small_credit cyc=%0d got=%0d exp<=2", c, dut_b.credit); end
            if (pop) begin
                n_cmp++; if (got_dat !== exp_dat) begin n_err++; $display("FAIL small_data cyc=%0d got=%h exp=%h", c, got_dat, exp_dat); end
            end
            if (acc) begin pv = 1'b0; sent++; end
        end
        n_cmp++; if (sent != 60 || q.size() != 0) begin n_err++; $display("FAIL small_complete sent=%0d left=%0d exp=60/0", sent, q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
